// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
//   AXI4-Lite slave exposing NUM_REGS read/write 32-bit registers.
//   Write address and write data are accepted independently; the write
//   commits on the edge where both halves are available, and the response
//   is presented from the following cycle. Reads take one cycle from the
//   address handshake, and a read never stalls behind a write.
//
// Build option:
//   AXI_LITE_REGFILE_MULT_EN - adds a two-stage 32x32 unsigned multiplier
//   (reg0 * reg1) readable at word index NUM_REGS (low word) and
//   NUM_REGS+1 (high word). Without it those indices are unmapped.
//
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*         AXI4-Lite write address / data / response
//   s_axi_ar*/r*            AXI4-Lite read address / data
//   regs_out                flattened register contents, reg i at [32*i +: 32]
//   wr_pulse                bit i pulses for one cycle after reg i is written

module axi_lite_regfile #(
  parameter int NUM_REGS  = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [31:0]            s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [31:0]            s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [NUM_REGS*32-1:0] regs_out,
  output logic [NUM_REGS-1:0]    wr_pulse
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam logic [IDX_BITS:0] NUM_REGS_IDX = (IDX_BITS+1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // ---------------------------------------------------------------- write
  w_state_t              w_state_reg, w_state_next;
  logic                  aw_held_reg;
  logic [IDX_BITS-1:0]   aw_idx_reg;
  logic                  w_held_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wstrb_reg;
  logic [1:0]            bresp_reg;
  logic [NUM_REGS-1:0]   wr_pulse_reg;
  logic [31:0]           regs_reg [NUM_REGS];

  logic                  aw_hs, w_hs, wr_commit, wr_hit;
  logic [IDX_BITS-1:0]   wr_idx;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [NUM_REGS-1:0]   wr_sel;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state_reg <= W_IDLE;
    else        w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (wr_commit) w_state_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        s_axi_awready = !aw_held_reg;
        s_axi_wready  = !w_held_reg;
      end
      W_RESP:  s_axi_bvalid = 1'b1;
      default: ;
    endcase
  end

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;

  // A half arriving this cycle is used directly, so a write whose second
  // half handshakes on edge N commits on edge N and responds right after.
  assign wr_idx    = aw_held_reg ? aw_idx_reg : s_axi_awaddr[ADDR_BITS-1:2];
  assign wr_data   = w_held_reg ? wdata_reg : s_axi_wdata;
  assign wr_strb   = w_held_reg ? wstrb_reg : s_axi_wstrb;
  assign wr_commit = (w_state_reg == W_IDLE) & (aw_held_reg | aw_hs) & (w_held_reg | w_hs);
  assign wr_hit    = wr_commit & ({1'b0, wr_idx} < NUM_REGS_IDX);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held_reg <= 1'b0;
      aw_idx_reg  <= '0;
      w_held_reg  <= 1'b0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      bresp_reg   <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      bresp_reg   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        aw_idx_reg  <= s_axi_awaddr[ADDR_BITS-1:2];
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= s_axi_wdata;
        wstrb_reg  <= s_axi_wstrb;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign wr_sel[gi] = wr_hit & (wr_idx == IDX_BITS'(gi));
    assign regs_out[32*gi +: 32] = regs_reg[gi];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
      wr_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= wr_sel;
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_sel[i])
          for (int k = 0; k < 4; k++)
            if (wr_strb[k]) regs_reg[i][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  assign s_axi_bresp = bresp_reg;
  assign wr_pulse    = wr_pulse_reg;

  // ------------------------------------------------------------ multiplier
`ifdef AXI_LITE_REGFILE_MULT_EN
  localparam logic [IDX_BITS:0] PROD_LO_IDX = (IDX_BITS+1)'(NUM_REGS);
  localparam logic [IDX_BITS:0] PROD_HI_IDX = (IDX_BITS+1)'(NUM_REGS + 1);
  logic [63:0] prod_s1_reg, prod_s2_reg;
  logic [31:0] mult_b;

  if (NUM_REGS > 1) begin : g_mult_b
    assign mult_b = regs_reg[1];
  end else begin : g_mult_b_zero
    assign mult_b = '0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      prod_s1_reg <= '0;
      prod_s2_reg <= '0;
    end else begin
      prod_s1_reg <= {32'b0, regs_reg[0]} * {32'b0, mult_b};
      prod_s2_reg <= prod_s1_reg;
    end
  end
`endif

  // ----------------------------------------------------------------- read
  r_state_t            r_state_reg, r_state_next;
  logic [31:0]         rdata_reg;
  logic [1:0]          rresp_reg;
  logic                ar_hs, rd_ok;
  logic [IDX_BITS:0]   rd_idx;
  logic [31:0]         rd_value;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state_reg <= R_IDLE;
    else        r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (s_axi_arvalid) r_state_next = R_DATA;
      R_DATA:  if (s_axi_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state_reg)
      R_IDLE:  s_axi_arready = 1'b1;
      R_DATA:  s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign rd_idx = {1'b0, s_axi_araddr[ADDR_BITS-1:2]};

  // Registers are sampled before this edge's write lands, so a colliding
  // read returns the pre-write value.
  always_comb begin
    rd_value = '0;
    rd_ok    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == (IDX_BITS+1)'(i)) begin
        rd_value = regs_reg[i];
        rd_ok    = 1'b1;
      end
    end
`ifdef AXI_LITE_REGFILE_MULT_EN
    if (rd_idx == PROD_LO_IDX) begin
      rd_value = prod_s2_reg[31:0];
      rd_ok    = 1'b1;
    end
    if (rd_idx == PROD_HI_IDX) begin
      rd_value = prod_s2_reg[63:32];
      rd_ok    = 1'b1;
    end
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_reg <= rd_value;
      rresp_reg <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi_rdata = rdata_reg;
  assign s_axi_rresp = rresp_reg;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[31:ADDR_BITS], s_axi_awaddr[1:0],
                              s_axi_araddr[31:ADDR_BITS], s_axi_araddr[1:0]};

endmodule
